multi_cycle_cpu: RTL

- Parametrised multi-cycle MIPS-subset core; the next generation of the single-cycle datapath.
- Each instruction executes over 2-5 states of one FSM and uses one unified external memory port with a req/ready handshake, so memory may insert wait states.
- Adds run/step gating, trap on illegal instructions, a retired-instruction counter and a register debug read port for the board display logic.

---
 rtl/multi_cycle_cpu.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core with one shared req/ready memory port,
// run gating, illegal-instruction trap, retire counter and debug GPR read.
module multi_cycle_cpu #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic [4:0]        test_addr,
    output logic [31:0]       test_out,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              trap,
    output logic [31:0]       retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       imm_q;
    logic [31:0]       alu_q;
    logic [31:0]       mdr_q;
    logic [31:0]       retired_q;
    logic              trap_q;
    logic              fetch_pend_q;
    logic [31:0]       gpr_q [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        legal_d;
    logic [31:0] alu_d;
    logic [31:0] br_off_d;
    logic [4:0]  wb_dest_d;
    logic [31:0] wb_data_d;
    logic        mem_fire;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    // Opcode / funct legality check used in DECODE
    always_comb begin
        legal_d = 1'b0;
        case (opcode)
            OP_RTYPE: legal_d = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND)
                                || (funct == F_OR) || (funct == F_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal_d = 1'b1;
            default:  legal_d = 1'b0;
        endcase
    end

    // ALU: R-type ops, otherwise base + immediate for addi/lw/sw
    always_comb begin
        alu_d = a_q + imm_q;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_ADD:   alu_d = a_q + b_q;
                F_SUB:   alu_d = a_q - b_q;
                F_AND:   alu_d = a_q & b_q;
                F_OR:    alu_d = a_q | b_q;
                F_SLT:   alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
                default: alu_d = a_q + b_q;
            endcase
        end
    end

    assign br_off_d  = {imm_q[29:0], 2'b00};
    assign wb_dest_d = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data_d = (opcode == OP_LW) ? mdr_q : alu_q;

    // Memory port: a fetch request, once raised, is held until it completes
    assign mem_req   = !reset && (((state_q == S_FETCH) && (run || fetch_pend_q))
                                  || (state_q == S_MEM));
    assign mem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? {alu_q[ADDR_W-1:2], 2'b00} : pc_q;
    assign mem_wdata = b_q;
    assign mem_fire  = mem_req && mem_ready;

    assign test_out = (test_addr == 5'd0) ? 32'd0 : gpr_q[test_addr];
    assign pc       = pc_q;
    assign state    = state_q;
    assign trap     = trap_q;
    assign retired  = retired_q;

    // Main FSM and architectural state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC[ADDR_W-1:0];
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            alu_q        <= '0;
            mdr_q        <= '0;
            retired_q    <= '0;
            trap_q       <= 1'b0;
            fetch_pend_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_fire) begin
                        ir_q         <= mem_rdata;
                        pc_q         <= pc_q + ADDR_W'(4);
                        fetch_pend_q <= 1'b0;
                        state_q      <= S_DECODE;
                    end else if (mem_req) begin
                        fetch_pend_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q   <= gpr_q[rs];
                    b_q   <= gpr_q[rt];
                    imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
                    if (opcode == OP_J) begin
                        pc_q      <= {ir_q[ADDR_W-3:0], 2'b00};
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                    end else if (!legal_d) begin
                        trap_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opcode == OP_BEQ) begin
                        if (a_q == b_q) begin
                            pc_q <= pc_q + br_off_d[ADDR_W-1:0];
                        end
                        retired_q <= retired_q + 32'd1;
                        state_q   <= S_FETCH;
                    end else begin
                        alu_q   <= alu_d;
                        state_q <= ((opcode == OP_LW) || (opcode == OP_SW)) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_fire) begin
                        if (opcode == OP_SW) begin
                            retired_q <= retired_q + 32'd1;
                            state_q   <= S_FETCH;
                        end else begin
                            mdr_q   <= mem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dest_d != 5'd0) begin
                        gpr_q[wb_dest_d] <= wb_data_d;
                    end
                    retired_q <= retired_q + 32'd1;
                    state_q   <= S_FETCH;
                end
                default: begin
                    state_q <= S_TRAP;
                end
            endcase
        end
    end

endmodule
